selftrigger_frame_builder: RTL and testbench

SELFTRIGGER_FRAME_BUILDER -- requirements
Module: selftrigger_frame_builder

---
 rtl/selftrigger_pkg.sv | 20 ++
 rtl/selftrigger_ring_ram.sv | 31 +++
 rtl/selftrigger_frame_builder.sv | 234 +++++++++++++++++++++++
 tb/tb_selftrigger_frame_builder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/selftrigger_pkg.sv
// Shared constants for the self-trigger frame builder.
// States, header layout and default geometry.
package selftrigger_pkg;

  localparam int DEF_PRETRIG    = 64;
  localparam int DEF_RECORD_LEN = 256;
  localparam int DEF_RING_DEPTH = 512;

  localparam logic [7:0] HDR_MARKER = 8'hA5;
  localparam int         HDR_LEN    = 5;

  typedef logic [2:0] state_t;

  localparam state_t ST_FILL    = 3'd0;
  localparam state_t ST_ARMED   = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_HEADER  = 3'd3;
  localparam state_t ST_READOUT = 3'd4;

endpackage

// File: rtl/selftrigger_ring_ram.sv
// Simple dual-port sample ring, one write and one read port.
// Registered read data appears one cycle after the read enable.
module selftrigger_ring_ram
  import selftrigger_pkg::*;
#(
  parameter int DEPTH = DEF_RING_DEPTH,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store one sample per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered output, block-RAM style.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/selftrigger_frame_builder.sv
// Captures a pre/post-trigger window from a sample ring and
// streams it as a header plus samples over valid/ready.
module selftrigger_frame_builder
  import selftrigger_pkg::*;
#(
  parameter int PRETRIG    = DEF_PRETRIG,
  parameter int RECORD_LEN = DEF_RECORD_LEN,
  parameter int RING_DEPTH = DEF_RING_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic signed [15:0] x,
  input  logic               trigger,
  input  logic [63:0]        timestamp,
  input  logic [7:0]         channel_id,
  output logic [15:0]        m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic [15:0]        dropped
);

  localparam int AW    = $clog2(RING_DEPTH);
  localparam int POST  = RECORD_LEN - PRETRIG;
  localparam int TOTAL = HDR_LEN + RECORD_LEN;
  localparam int IW    = $clog2(TOTAL + 1);
  localparam int CW    = $clog2(RECORD_LEN + 1);

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [63:0]     ts_q;
  logic [15:0]     drop_q;

  logic            wr_en;
  logic            trig_ok;
  logic            drop_ev;
  logic            issue;
  logic            rd_en;
  logic [15:0]     rdata;
  logic [15:0]     hdr_word;

  logic            p1_valid;
  logic            p1_hdr;
  logic            p1_last;
  logic [15:0]     p1_word;
  logic [16:0]     in_word;

  logic [16:0]     ent0;
  logic [16:0]     ent1;
  logic [1:0]      occ;
  logic [1:0]      occ_next;
  logic            push;
  logic            pop;

  assign wr_en = enable &&
    (state == ST_FILL || state == ST_ARMED ||
     state == ST_CAPTURE);
  assign trig_ok = trigger && enable &&
    (state == ST_ARMED);
  assign drop_ev = trigger && enable &&
    (state != ST_ARMED);

  assign push     = p1_valid;
  assign pop      = m_valid && m_ready;
  assign occ_next = occ + {1'b0, push} - {1'b0, pop};
  assign rd_en    = issue && (state == ST_READOUT);
  assign in_word  = {p1_last, p1_hdr ? p1_word : rdata};

  assign m_valid = (occ != 2'd0);
  assign m_data  = ent0[15:0];
  assign m_last  = m_valid && ent0[16];
  assign busy    = (state != ST_ARMED);
  assign dropped = drop_q;

  selftrigger_ring_ram #(
    .DEPTH (RING_DEPTH),
    .WIDTH (16)
  ) u_ring (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (x),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Issue a word only if the skid buffer can absorb it next cycle.
  always_comb begin
    issue = 1'b0;
    if (occ_next != 2'd2) begin
      if (state == ST_HEADER) issue = 1'b1;
      else if (state == ST_READOUT &&
               idx < IW'(TOTAL)) issue = 1'b1;
    end
  end

  // Header word select: marker/channel, then timestamp MSW first.
  always_comb begin
    hdr_word = {HDR_MARKER, channel_id};
    unique case (1'b1)
      idx[2:0] == 3'd1: hdr_word = ts_q[63:48];
      idx[2:0] == 3'd2: hdr_word = ts_q[47:32];
      idx[2:0] == 3'd3: hdr_word = ts_q[31:16];
      idx[2:0] == 3'd4: hdr_word = ts_q[15:0];
      default: ;
    endcase
  end

  // Capture/readout sequencing and ring pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_FILL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      idx    <= '0;
      ts_q   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      unique case (state)
        ST_FILL: begin
          if (enable) begin
            if (cnt == CW'(PRETRIG - 1)) begin
              cnt   <= '0;
              state <= ST_ARMED;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_ARMED: begin
          if (trig_ok) begin
            ts_q   <= timestamp;
            rd_ptr <= wr_ptr - AW'(PRETRIG);
            idx    <= '0;
            if (POST == 1) begin
              state <= ST_HEADER;
            end else begin
              cnt   <= CW'(1);
              state <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (enable) begin
            if (cnt == CW'(POST - 1)) begin
              cnt   <= '0;
              state <= ST_HEADER;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_HEADER: begin
          if (issue) begin
            idx <= idx + IW'(1);
            if (idx == IW'(HDR_LEN - 1))
              state <= ST_READOUT;
          end
        end
        ST_READOUT: begin
          if (issue) begin
            idx    <= idx + IW'(1);
            rd_ptr <= rd_ptr + AW'(1);
          end
          if (pop && m_last) begin
            cnt   <= '0;
            state <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  // Pipeline stage aligning header words with RAM read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_valid <= 1'b0;
      p1_hdr   <= 1'b0;
      p1_last  <= 1'b0;
      p1_word  <= '0;
    end else begin
      p1_valid <= issue;
      p1_hdr   <= (state == ST_HEADER);
      p1_last  <= issue && (state == ST_READOUT) &&
                  (idx == IW'(TOTAL - 1));
      p1_word  <= hdr_word;
    end
  end

  // Two-entry skid buffer; ent0 is the presented word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= 2'd0;
    end else begin
      occ <= occ_next;
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= in_word;
          else             ent1 <= in_word;
        end
        2'b01: ent0 <= ent1;
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= in_word;
          end else begin
            ent0 <= ent1;
            ent1 <= in_word;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating count of triggers that could not be captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else if (drop_ev && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_selftrigger_frame_builder.sv
// Bench for selftrigger_frame_builder: directed scenarios with
// randomized data/handshake against a record-level model.
module tb_selftrigger_frame_builder;

  localparam int PRE   = 64;
  localparam int REC   = 256;
  localparam int POST  = REC - PRE;
  localparam int DEPTH = 512;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic signed [15:0] x = '0;
  logic               trigger = 1'b0;
  logic [63:0]        timestamp = '0;
  logic [7:0]         channel_id = 8'h3C;
  logic [15:0]        m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic               m_last;
  logic               busy;
  logic [15:0]        dropped;

  always #5 clk = ~clk;

  selftrigger_frame_builder #(
    .PRETRIG    (PRE),
    .RECORD_LEN (REC),
    .RING_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .x          (x),
    .trigger    (trigger),
    .timestamp  (timestamp),
    .channel_id (channel_id),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .dropped    (dropped)
  );

  typedef enum {M_FILL, M_ARMED, M_CAP, M_OUT} mst_t;

  int          tests = 0;
  int          fails = 0;
  mst_t        mst = M_FILL;
  int          mfill, mcap, widx, mt, lat_cnt, rdy_mode;
  logic [15:0] mdrop;
  logic [63:0] mts;
  logic [15:0] hist [0:65535];
  logic [16:0] expq [$];
  logic [16:0] prev_word;
  bit          prev_stall, lat_pend, ramp;
  logic [63:0] tsc;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic bit en_rand(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic wr(input logic [15:0] v);
    hist[widx[15:0]] = v;
    widx++;
  endtask

  task automatic build_record();
    expq.push_back({1'b0, 8'hA5, channel_id});
    expq.push_back({1'b0, mts[63:48]});
    expq.push_back({1'b0, mts[47:32]});
    expq.push_back({1'b0, mts[31:16]});
    expq.push_back({1'b0, mts[15:0]});
    for (int k = 0; k < REC; k++)
      expq.push_back({k == REC - 1, hist[mt - PRE + k]});
  endtask

  task automatic step(input bit en, input bit trg);
    logic [15:0] xv;
    logic [16:0] cur;
    bit          last_x;
    @(negedge clk);
    xv = ramp ? widx[15:0] : 16'($urandom);
    enable    = en;
    trigger   = trg;
    x         = xv;
    timestamp = tsc;
    tsc       = tsc + 64'd1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = ($urandom_range(0, 2) != 0);
    endcase
    chk("busy", busy, mst != M_ARMED);
    chk("dropped", dropped, mdrop);
    if (lat_pend) begin
      lat_cnt++;
      if (lat_cnt == 3) begin
        chk("first_valid", m_valid, 1);
        lat_pend = 1'b0;
      end
    end
    cur = {m_last, m_data};
    if (prev_stall)
      chk("stall_hold", {m_valid, cur}, {1'b1, prev_word});
    last_x = 1'b0;
    if (m_valid && m_ready) begin
      if (expq.size() == 0) begin
        chk("extra_word", {1'b1, cur}, 64'h0);
      end else begin
        chk("word", cur, expq[0]);
        last_x = expq[0][16];
        void'(expq.pop_front());
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_word  = cur;
    if (en && trg && mst != M_ARMED && mdrop != 16'hFFFF)
      mdrop++;
    case (mst)
      M_FILL: if (en) begin
        wr(xv);
        mfill++;
        if (mfill == PRE) mst = M_ARMED;
      end
      M_ARMED: if (en) begin
        wr(xv);
        if (trg) begin
          mt   = widx - 1;
          mts  = timestamp;
          mcap = 1;
          mst  = M_CAP;
        end
      end
      M_CAP: if (en) begin
        wr(xv);
        mcap++;
      end
      M_OUT: if (last_x) begin
        mst   = M_FILL;
        mfill = 0;
      end
    endcase
    if (mst == M_CAP && mcap == POST) begin
      build_record();
      mst      = M_OUT;
      lat_pend = 1'b1;
      lat_cnt  = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    enable  = 1'b0;
    trigger = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_dropped", dropped, 0);
    repeat (3) @(negedge clk);
    reset_n    = 1'b1;
    mst        = M_FILL;
    mfill      = 0;
    widx       = 0;
    mdrop      = '0;
    prev_stall = 1'b0;
    lat_pend   = 1'b0;
    expq.delete();
  endtask

  task automatic run_until(input mst_t target, input int pct,
                           input int budget, input string tag);
    int n;
    n = 0;
    while (mst != target && n < budget) begin
      step(en_rand(pct), 1'b0);
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  task automatic finish_record(input string tag);
    run_until(M_FILL, 100, 3000, tag);
    chk({tag, "_drained"}, expq.size(), 0);
  endtask

  initial begin
    int n;
    ramp     = 1'b1;
    rdy_mode = 0;
    tsc      = 64'h1234_5678_9ABC_0000;
    mdrop    = '0;
    do_reset();

    repeat (9) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    run_until(M_ARMED, 100, 200, "arm1");
    n = 0;
    while (widx < 100 && n < 200) begin
      step(1'b1, 1'b0);
      n++;
    end
    step(1'b1, 1'b1);
    chk("t_is_100", mt, 100);
    run_until(M_OUT, 100, 400, "cap1");
    repeat (40) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    finish_record("rec1");
    chk("drop_two", dropped, 2);

    rdy_mode = 1;
    run_until(M_ARMED, 100, 200, "arm2");
    step(1'b1, 1'b1);
    finish_record("rec2");

    rdy_mode = 2;
    run_until(M_ARMED, 100, 200, "arm3");
    n = 0;
    while (widx % DEPTH != 500 && n < 600) begin
      step(1'b1, 1'b0);
      n++;
    end
    step(1'b1, 1'b1);
    chk("wrap_taddr", mt % DEPTH, 500);
    finish_record("rec3");

    rdy_mode = 0;
    run_until(M_ARMED, 100, 200, "arm4");
    step(1'b1, 1'b1);
    repeat (50) step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    chk("frozen_cap", mcap, 51);
    finish_record("rec4");

    ramp     = 1'b0;
    rdy_mode = 2;
    for (int r = 0; r < 3; r++) begin
      run_until(M_ARMED, 70, 400, "arm_rnd");
      repeat ($urandom_range(0, 30))
        step(en_rand(70), 1'b0);
      step(1'b1, 1'b1);
      n = 0;
      while (mst != M_FILL && n < 3000) begin
        step(en_rand(70), $urandom_range(0, 15) == 0);
        n++;
      end
      chk("rnd_done", n < 3000, 1);
    end

    ramp     = 1'b1;
    rdy_mode = 0;
    run_until(M_ARMED, 100, 200, "arm5");
    step(1'b1, 1'b1);
    run_until(M_OUT, 100, 400, "cap5");
    repeat (100) step(1'b1, 1'b0);
    do_reset();
    run_until(M_ARMED, 100, 200, "refill");
    chk("refill_writes", widx, PRE);
    step(1'b1, 1'b1);
    finish_record("rec6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
